// File: rtl/fetch_unit_if.sv
// Fetch unit bundle: instruction memory port, redirect input and
// the instruction stream handed to the control unit.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    output imem_req, imem_addr,
    output instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata,
    input  redirect_valid, redirect_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    input  instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata,
    output redirect_valid, redirect_pc,
    output instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential prefetch into a small FIFO,
// redirect flush, and draining of one stale in-flight read.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] CAP = 3'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t        state_q, state_d;
  logic          run_q;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   daddr_q;
  logic [31:0]   buf_pc_q   [DEPTH];
  logic [31:0]   buf_word_q [DEPTH];
  logic [AW-1:0] head_q, tail_q;
  logic [2:0]    cnt_q;
  logic          req, ack, push, pop, flush, valid;

  function automatic logic [AW-1:0] bump(
    input logic [AW-1:0] p
  );
    return (p == LAST) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    req     = 1'b0;
    state_d = state_q;
    pc_d    = pc_q;
    valid   = (cnt_q != 3'd0);
    flush   = bus.redirect_valid;
    // run_q holds the request low for the first cycle out of reset
    if (run_q)
      req = (state_q == DRAIN) || (cnt_q < CAP);
    ack  = req && bus.imem_ack;
    push = (state_q == FETCH) && ack && !flush;
    pop  = valid && bus.instr_ready && !flush;
    if (flush)
      pc_d = {bus.redirect_pc[31:2], 2'b00};
    else if (push)
      pc_d = pc_q + 32'd4;
    unique case (state_q)
      FETCH:
        if (flush && req && !bus.imem_ack)
          state_d = DRAIN;
      DRAIN:
        if (ack)
          state_d = FETCH;
      default:
        state_d = FETCH;
    endcase
  end

  // In DRAIN pc already holds the redirect target; the bus keeps
  // the address of the read still in flight.
  assign bus.imem_req    = req;
  assign bus.imem_addr   = (state_q == DRAIN) ? daddr_q : pc_q;
  assign bus.instr_valid = valid;
  assign bus.instr       = valid ? buf_word_q[head_q] : NOP;
  assign bus.instr_pc    = valid ? buf_pc_q[head_q] : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      run_q   <= 1'b0;
      pc_q    <= RESET_PC;
      daddr_q <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= 3'd0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_pc_q[i]   <= 32'd0;
        buf_word_q[i] <= NOP;
      end
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      pc_q    <= pc_d;
      if (state_q == FETCH)
        daddr_q <= pc_q;
      if (flush) begin
        head_q <= '0;
        tail_q <= '0;
        cnt_q  <= 3'd0;
      end else begin
        if (push) begin
          buf_pc_q[tail_q]   <= pc_q;
          buf_word_q[tail_q] <= bus.imem_rdata;
          tail_q             <= bump(tail_q);
        end
        if (pop)
          head_q <= bump(head_q);
        cnt_q <= cnt_q + 3'(push) - 3'(pop);
      end
    end
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 2: prefetch buffer entries (range 1..4).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  32  word-aligned fetch address; valid while imem_req=1.
REQ-007 imem_ack  input  1  memory completes the read at this edge when sampled with imem_req=1.
REQ-008 imem_rdata  input  32  read data; valid in the imem_ack cycle.
REQ-009 redirect_valid  input  1  control-flow change (branch/jump taken).
REQ-010 redirect_pc  input  32  new fetch target.
REQ-011 instr_valid  output  1  buffer head holds a valid instruction for the control unit.
REQ-012 instr  output  32  head instruction word.
REQ-013 instr_pc  output  32  address of the head instruction.
REQ-014 instr_ready  input  1  consumer accepts the head at this edge when instr_valid=1.

Function
REQ-015 States: FETCH (normal) and DRAIN (discarding one stale in-flight read).
REQ-016 Hold pc register (next fetch address) and a DEPTH-entry FIFO of {pc, word}.
REQ-017 imem_req = 1 in DRAIN; in FETCH, imem_req = 1 iff FIFO count < DEPTH; imem_addr = pc.
REQ-018 Once imem_req rises, imem_req and imem_addr stay stable until imem_ack (pops only lower count, so no deassert).
REQ-019 FETCH, imem_req & imem_ack & no redirect: push {pc, imem_rdata}; pc <= pc + 4 (mod 2^32 wrap).
REQ-020 Back-to-back: imem_req may remain 1 on the next cycle with the new pc; one transaction per cycle max; at most one outstanding.
REQ-021 instr_valid = FIFO not empty; instr/instr_pc = head; pop on instr_valid & instr_ready.
REQ-022 Empty FIFO: instr = 32'h00000013 (NOP), instr_pc = 0, instr_valid = 0.
REQ-023 Push and pop in the same cycle: count unchanged, order preserved.
REQ-024 Fetch-to-instr_valid latency: 1 cycle after the imem_ack edge.
REQ-025 redirect_valid (any state) has priority: flush FIFO (count <= 0, instr_valid = 0 next cycle); pc <= {redirect_pc[31:2], 2'b00}; same-cycle pop and push are discarded.
REQ-026 Redirect in FETCH with imem_req=1 and imem_ack=0: go DRAIN; imem_addr keeps the old address until ack.
REQ-027 Redirect in FETCH with imem_ack=1 or imem_req=0: stay FETCH; next cycle request the redirect target.
REQ-028 DRAIN: on imem_ack discard imem_rdata, no push, go FETCH; pc unchanged.
REQ-029 Redirect in DRAIN: update pc, flush, remain DRAIN until ack.
REQ-030 imem_ack with imem_req=0 is ignored.

Reset
REQ-031 rst=1 asynchronously sets: state FETCH, pc = RESET_PC, FIFO empty, instr_valid 0, instr 32'h00000013, instr_pc 0, imem_req 0.
REQ-032 imem_req first rises the cycle after rst deasserts, with imem_addr = RESET_PC.
REQ-033 rst mid-transaction abandons the outstanding read; a late imem_ack is ignored (REQ-030).

Verification
REQ-034 Reset release, imem_ack held 1, instr_ready 1 -> imem_addr 0,4,8,... on consecutive cycles; instr_pc trails by 1 cycle; instr matches imem_rdata.
REQ-035 instr_ready 0, imem_ack 1 -> exactly DEPTH words buffered (pc 0, 4), imem_req drops to 0; set instr_ready 1 -> imem_req rises after the first pop, no word lost or duplicated.
REQ-036 imem_req at addr 0x10, ack delayed 3 cycles, redirect_pc 0x203 in cycle 1 -> imem_addr stays 0x10 until ack, data dropped; next request at 0x200; first instr_pc 0x200.
REQ-037 Redirect to 0x80 coincident with imem_ack at 0x14 and instr_ready 1 -> FIFO empties, 0x14 data never appears, next imem_addr 0x80.
REQ-038 pc = 32'hFFFFFFFC, ack -> next imem_addr 32'h00000000.
REQ-039 Assert rst during an outstanding request with pending ack -> outputs at reset values immediately; first post-reset fetch at RESET_PC; stale ack pushes nothing.
